// File: rtl/multdiv_ctrl_if.sv
// Pipeline/unit-side bundle of the multiply/divide issue controller.
// slave = controller view, master = pipeline and arithmetic unit view.
interface multdiv_ctrl_if #(
  parameter int RD_W = 5
) ();
  logic            flush;
  logic            req_valid;
  logic            req_is_div;
  logic [31:0]     req_opA;
  logic [31:0]     req_opB;
  logic [RD_W-1:0] req_rd;
  logic            req_ready;
  logic            busy;
  logic [31:0]     unit_operandA;
  logic [31:0]     unit_operandB;
  logic            ctrl_MULT;
  logic            ctrl_DIV;
  logic [31:0]     unit_result;
  logic            unit_exception;
  logic            unit_resultRDY;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            wb_exception;

  modport slave (
    input  flush, req_valid, req_is_div,
    input  req_opA, req_opB, req_rd,
    input  unit_result, unit_exception,
    input  unit_resultRDY,
    output req_ready, busy,
    output unit_operandA, unit_operandB,
    output ctrl_MULT, ctrl_DIV,
    output wb_valid, wb_rd, wb_data,
    output wb_exception
  );

  modport master (
    output flush, req_valid, req_is_div,
    output req_opA, req_opB, req_rd,
    output unit_result, unit_exception,
    output unit_resultRDY,
    input  req_ready, busy,
    input  unit_operandA, unit_operandB,
    input  ctrl_MULT, ctrl_DIV,
    input  wb_valid, wb_rd, wb_data,
    input  wb_exception
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Issue/sequencing controller for the shared iterative mult/div units.
// Define MULTDIV_SHORTCUT_EN to complete zero-operand ops without the unit.
module multdiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int RD_W           = 5
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_ctrl_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic [31:0]     res_q, res_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            div_q, div_d;
  logic            exc_q, exc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            wb_en;

`ifdef MULTDIV_SHORTCUT_EN
  logic shortcut;
  assign shortcut = bus.req_is_div ?
    (bus.req_opB == '0) :
    ((bus.req_opA == '0) | (bus.req_opB == '0));
`endif

  assign accept = bus.req_valid & ~bus.flush
                & (state_q == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      exc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    rd_d    = rd_q;
    div_d   = div_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = bus.req_opA;
          opb_d   = bus.req_opB;
          rd_d    = bus.req_rd;
          div_d   = bus.req_is_div;
          state_d = START;
`ifdef MULTDIV_SHORTCUT_EN
          if (shortcut) begin
            res_d   = '0;
            exc_d   = bus.req_is_div;
            state_d = DONE;
          end
`endif
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // a result arriving on the limit cycle beats the timeout
        if (bus.unit_resultRDY) begin
          res_d   = bus.unit_result;
          exc_d   = bus.unit_exception;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  assign wb_en = (state_q == DONE) & (rd_q != '0)
               & ~bus.flush & ~reset;

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.unit_operandA = opa_q;
  assign bus.unit_operandB = opb_q;
  assign bus.ctrl_MULT     = (state_q == START) & ~div_q;
  assign bus.ctrl_DIV      = (state_q == START) & div_q;
  assign bus.wb_valid      = wb_en;
  assign bus.wb_rd         = wb_en ? rd_q : '0;
  assign bus.wb_data       = wb_en ? res_q : '0;
  assign bus.wb_exception  = wb_en & exc_q;
endmodule
